// File: rtl/wb_ram_slave.sv
// wb_ram_slave: Wishbone B4 single-port RAM slave, 2^ADDR_W x 32-bit words.
// WAIT_STATES idle cycles (0..15) precede the first ack of each transfer.
// The read port is registered and byte-lane writes follow wb_sel_i.
// The optional macro WB_RAM_SLAVE_BURST_EN enables incrementing bursts
// (cti 010 / 111). Without it, every beat is handled as a classic transfer.
module wb_ram_slave #(
  parameter int ADDR_W      = 10,
  parameter int WAIT_STATES = 1
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic [31:0] wb_adr_i,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] wb_dat_o,
  input  logic [3:0]  wb_sel_i,
  input  logic [2:0]  wb_cti_i,
  input  logic        wb_we_i,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  output logic        wb_ack_o
);

  localparam logic [3:0] WS4        = 4'(WAIT_STATES);
  localparam logic [2:0] CTI_INCR   = 3'b010;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_ACK   = 2'd2,
    ST_BURST = 2'd3
  } state_t;

  state_t            state_q;
  logic [3:0]        cnt_q;
  logic              ack_q;
  logic              we_q;
  logic [ADDR_W-1:0] idx_q;
  logic [31:0]       dat_q;

  logic [31:0]       mem [2**ADDR_W];

  logic [ADDR_W-1:0] adr_idx;
  logic [ADDR_W-1:0] idx_nxt;
  logic              req;
  logic              wr_en;
  logic              unused_ok;

  assign adr_idx  = wb_adr_i[ADDR_W+1:2];
  assign idx_nxt  = idx_q + 1'b1;
  assign req      = wb_cyc_i & wb_stb_i;
  // A write lands at the edge that closes an acked cycle, with live bus data.
  assign wr_en    = ack_q & req & wb_we_i;
  assign wb_ack_o = ack_q & wb_cyc_i;
  assign wb_dat_o = dat_q;

  // Address bits outside the word index (and cti when bursts are off) are don't-care.
  assign unused_ok = ^{wb_adr_i[31:ADDR_W+2], wb_adr_i[1:0], wb_cti_i};

  // Transfer sequencing: latch request, count wait states, raise ack, load read data.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      ack_q   <= 1'b0;
      we_q    <= 1'b0;
      idx_q   <= '0;
      dat_q   <= 32'h0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req) begin
            idx_q <= adr_idx;
            we_q  <= wb_we_i;
            cnt_q <= WS4;
            if (WAIT_STATES == 0) begin
              state_q <= ST_ACK;
              ack_q   <= 1'b1;
              if (!wb_we_i) dat_q <= mem[adr_idx];
            end else begin
              state_q <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (!req) begin
            // Master abandoned the request: no ack, nothing written.
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
          end else if (cnt_q <= 4'd1) begin
            state_q <= ST_ACK;
            ack_q   <= 1'b1;
            cnt_q   <= 4'd0;
            if (!we_q) dat_q <= mem[idx_q];
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
`ifdef WB_RAM_SLAVE_BURST_EN
        ST_ACK, ST_BURST: begin
          if (req && (wb_cti_i == CTI_INCR)) begin
            // Next beat follows with no gap; the index wraps at the top of memory.
            state_q <= ST_BURST;
            idx_q   <= idx_nxt;
            if (!we_q) dat_q <= mem[idx_nxt];
          end else begin
            // End-of-burst, any other cti, or stb/cyc low closes the transfer.
            state_q <= ST_IDLE;
            ack_q   <= 1'b0;
          end
        end
`else
        ST_ACK, ST_BURST: begin
          state_q <= ST_IDLE;
          ack_q   <= 1'b0;
        end
`endif
        default: begin
          state_q <= ST_IDLE;
          ack_q   <= 1'b0;
        end
      endcase
    end
  end

  // Byte-lane write port; memory contents are deliberately never reset.
  always_ff @(posedge sys_clk) begin
    if (wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (wb_sel_i[b]) mem[idx_q][8*b +: 8] <= wb_dat_i[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_wb_ram_slave.sv
// tb_wb_ram_slave: directed-vector bench for wb_ram_slave (WAIT_STATES=1).
// Covers reset values, full and partial writes, aborted requests, address
// aliasing, the wrapping four-beat sequence and reset during a wait state.
module tb_wb_ram_slave;

  localparam int WS = 1;

  logic        clk;
  logic        rst_n;
  logic [31:0] adr;
  logic [31:0] dat_w;
  logic [31:0] dat_r;
  logic [3:0]  sel;
  logic [2:0]  cti;
  logic        we;
  logic        cyc;
  logic        stb;
  logic        ack;

  int n_cmp;
  int n_bad;

  wb_ram_slave #(.ADDR_W(10), .WAIT_STATES(WS)) dut (
    .sys_clk   (clk),
    .sys_rst_n (rst_n),
    .wb_adr_i  (adr),
    .wb_dat_i  (dat_w),
    .wb_dat_o  (dat_r),
    .wb_sel_i  (sel),
    .wb_cti_i  (cti),
    .wb_we_i   (we),
    .wb_cyc_i  (cyc),
    .wb_stb_i  (stb),
    .wb_ack_o  (ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // Single classic transfer; checks ack latency and that ack drops afterwards.
  task automatic xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] s, input string tag, output logic [31:0] rd);
    int lat;
    lat = -1;
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat_w = d; sel = s; cti = 3'b000;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (ack) begin
        lat = i;
        break;
      end
    end
    rd = dat_r;
    check_eq({tag, " latency"}, lat, WS + 1);
    @(posedge clk); #1;
    stb = 1'b0; we = 1'b0;
    @(negedge clk);
    check_eq({tag, " ack drop"}, {31'd0, ack}, 32'd0);
    cyc = 1'b0;
  endtask

  logic [31:0] rd;
  logic [31:0] badr [4];
  logic [2:0]  bcti [4];
  logic [31:0] bdat [4];
  int          bexp [4];
  int          ack_cyc [4];
  logic [31:0] ack_dat [4];
  int          b;
  int          cyc_n;
  int          ack_seen;

  initial begin
    n_cmp = 0; n_bad = 0;
    rst_n = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0;
    adr = '0; dat_w = '0; sel = '0; cti = '0;
    badr = '{32'h0000_0FFC, 32'h0000_0000, 32'h0000_0004, 32'h0000_0008};
    bcti = '{3'b010, 3'b010, 3'b010, 3'b111};
    bdat = '{32'hAAAA_0001, 32'hBBBB_0002, 32'hCCCC_0003, 32'hDDDD_0004};
`ifdef WB_RAM_SLAVE_BURST_EN
    bexp = '{2, 3, 4, 5};
`else
    bexp = '{2, 5, 8, 11};
`endif

    // Reset values, observed with cyc high so the raw ack register shows.
    repeat (3) @(posedge clk);
    #1 cyc = 1'b1;
    @(negedge clk);
    check_eq("reset ack", {31'd0, ack}, 32'd0);
    check_eq("reset dat", dat_r, 32'h0);
    cyc = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;

    // Full write then read back.
    xfer(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, "wr full", rd);
    xfer(1'b0, 32'h10, 32'h0, 4'hF, "rd full", rd);
    check_eq("rd full data", rd, 32'hDEADBEEF);

    // Partial write on lanes 0 and 2.
    xfer(1'b1, 32'h10, 32'h11223344, 4'b0101, "wr part", rd);
    xfer(1'b0, 32'h10, 32'h0, 4'hF, "rd part", rd);
    check_eq("rd part data", rd, 32'hDE22BE44);

    // Read request abandoned during WAIT: no ack may appear.
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h10; sel = 4'hF;
    @(posedge clk); #1;
    cyc = 1'b0; stb = 1'b0;
    ack_seen = 0;
    @(posedge clk); #1 cyc = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (ack) ack_seen++;
    end
    cyc = 1'b0;
    check_eq("abort rd acks", ack_seen, 0);

    // Write request abandoned during WAIT: memory must be untouched.
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 32'h10; dat_w = 32'h0; sel = 4'hF;
    @(posedge clk); #1;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    xfer(1'b0, 32'h10, 32'h0, 4'hF, "rd post abort", rd);
    check_eq("abort keeps mem", rd, 32'hDE22BE44);

    // Same word still writable; upper address bits alias to the same index.
    xfer(1'b1, 32'h10, 32'hCAFEF00D, 4'hF, "wr again", rd);
    xfer(1'b0, 32'h1010, 32'h0, 4'hF, "rd alias", rd);
    check_eq("alias data", rd, 32'hCAFEF00D);

    // Preload words at 0x3FF and 0..2, then run the four-beat sequence.
    for (int i = 0; i < 4; i++) xfer(1'b1, badr[i], bdat[i], 4'hF, "preload", rd);
    b = 0; cyc_n = 0;
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we = 1'b0; sel = 4'hF; adr = badr[0]; cti = bcti[0];
    while (b < 4 && cyc_n < 40) begin
      @(negedge clk);
      if (ack) begin
        ack_cyc[b] = cyc_n;
        ack_dat[b] = dat_r;
        b++;
      end
      cyc_n++;
      @(posedge clk); #1;
      if (b < 4) begin
        adr = badr[b];
        cti = bcti[b];
      end else begin
        stb = 1'b0;
      end
    end
    check_eq("seq beats", b, 4);
    @(negedge clk);
    check_eq("seq end ack", {31'd0, ack}, 32'd0);
    cyc = 1'b0; stb = 1'b0; cti = 3'b000;
    for (int i = 0; i < 4; i++) begin
      check_eq($sformatf("seq data %0d", i), ack_dat[i], bdat[i]);
      check_eq($sformatf("seq cycle %0d", i), ack_cyc[i], bexp[i]);
    end

    // Reset pulsed while a write sits in WAIT.
    xfer(1'b1, 32'h20, 32'h5A5AA5A5, 4'hF, "wr rst tgt", rd);
    xfer(1'b0, 32'h20, 32'h0, 4'hF, "rd rst tgt", rd);
    check_eq("rst tgt data", rd, 32'h5A5AA5A5);
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 32'h20; dat_w = 32'hFFFFFFFF; sel = 4'hF;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check_eq("rst async dat", dat_r, 32'h0);
    check_eq("rst async ack", {31'd0, ack}, 32'd0);
    @(posedge clk); #1;
    check_eq("rst held ack", {31'd0, ack}, 32'd0);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    xfer(1'b0, 32'h20, 32'h0, 4'hF, "rd after rst", rd);
    check_eq("rst keeps mem", rd, 32'h5A5AA5A5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
